row_skew_feeder: RTL and testbench
==================================

// Module: row_skew_feeder
// PURPOSE
//  Downstream consumer of the per-row input buffers. Pops each row buffer in diagonal (skewed) order:
//  row r starts r cycles after row 0, which is the wavefront the systolic array needs.
//  Presents zero-padded, aligned operands plus per-row valid to the array edge.
//  Tracks tile progress, stalls all rows together on any buffer underrun, and reports done.
// PARAMETERS
//  ROWS    4   number of row buffers / systolic array rows
//  DWIDTH  16  operand width; must match the row buffers' DWIDTH
//  K_LEN   3   operands popped per row per tile (1..255)
// PORTS
//  clk          in   1            single clock; drives the row buffers' rd_clk
//  rstn         in   1            synchronous reset, ACTIVE-HIGH (despite the name)
//  start        in   1            tile start request, sampled in IDLE only
//  buf_empty    in   ROWS         empty flag of each row buffer
//  buf_dout     in   ROWS*DWIDTH  registered dout of each row buffer; row r at [r*DWIDTH +: DWIDTH]
//  buf_rd_en    out  ROWS         pop request to each row buffer
//  sa_data      out  ROWS*DWIDTH  operands to the array; 0 when the lane is not valid
//  sa_valid     out  ROWS         lane r carries a real operand this cycle
//  busy         out  1            high in FEED and DRAIN
//  done         out  1            one-cycle pulse in DONE
// BEHAVIOUR
//  - Reset: state=IDLE, t=0. buf_rd_en, sa_valid, busy and done are 0. sa_data=0.
//  - FSM states:
//    - IDLE -> FEED on start; t is cleared to 0.
//    - FEED -> DRAIN when t==ROWS+K_LEN-2 and the cycle is not stalled.
//    - DRAIN -> DONE after 1 cycle.
//    - DONE -> IDLE after 1 cycle.
//  - Issue counter t: width $clog2(ROWS+K_LEN). Increments in FEED on every non-stalled cycle.
//  - active[r] = (t >= r) && (t < r+K_LEN).
//  - stall = OR over r of (active[r] & buf_empty[r]).
//    - On a stall, every row is held: no rd_en on any row, and t does not advance.
//    - This keeps the wavefront aligned.
//  - buf_rd_en[r] = (state==FEED) & active[r] & !stall. Combinational from registered state and inputs.
//  - sa_valid[r] is a register loaded with buf_rd_en[r]. Latency 1 cycle, matching the buffer's registered dout.
//  - sa_data lane r = sa_valid[r] ? buf_dout[r] : 0.
//    - The buffer holds its stale dout, so masking is mandatory.
//  - The last pop happens in the final FEED cycle, and its sa_valid appears in DRAIN.
//  - start in FEED, DRAIN or DONE is ignored (no queueing).
//  - Reset in any state aborts: IDLE, all outputs 0 on the next edge. Buffer pointers are not this block's concern.
//  - Bursts of stall cycles are unbounded. There is no timeout.
// CONFIGURATION
//  - ROW_FEEDER_STALL_CNT_EN defined:
//    - Adds output port stall_cycles [31:0].
//    - It counts cycles in FEED with stall=1, clears on the IDLE->FEED transition and on reset, and saturates at 2^32-1.
//    - It holds its value after DONE until the next start.
//  - Not defined: the port and the counter are absent. All other behaviour is identical.
// STRUCTURE
//  - In package Config:
//    - typedef enum logic [1:0] {FS_IDLE, FS_FEED, FS_DRAIN, FS_DONE} feeder_state_t.
//    - Default constants SA_ROWS and SA_DWIDTH, used to set ROWS/DWIDTH at instantiation.
//  - Sub-module row_feeder_lane, one per row (generate loop):
//    - Inputs: lane index r, t, state and stall.
//    - Outputs: buf_rd_en, the sa_valid register and the masked sa_data lane.
//  - The top holds the FSM, t, the stall reduction and the optional stall counter.
// TESTING  (ROWS=4, K_LEN=3, DWIDTH=16; row buffers modelled as preloaded FIFOs, row r holding r*16+{1,2,3})
//  1. rstn=1 for 2 cycles
//     -> buf_rd_en=0, sa_valid=0, sa_data=0, busy=0, done=0.
//  2. start pulse at c0, all buffers non-empty:
//     -> buf_rd_en = 0001, 0011, 0111, 1110, 1100, 1000 on c1..c6.
//     -> sa_valid is the same pattern on c2..c7, with row 2 data 0x21, 0x22, 0x23 on c4..c6.
//     -> done=1 at c8 only; busy=1 on c1..c7.
//  3. As test 2, but buf_empty[1]=1 on c2..c3:
//     -> buf_rd_en=0000 on c2 and c3.
//     -> Pattern resumes at c4 with 0011; done at c10.
//     -> sa_data is all 0 while sa_valid=0.
//  4. start held high through a whole tile -> exactly one tile issued.
//     -> After DONE the FSM returns to IDLE and a new tile starts the cycle after (start sampled in IDLE).
//  5. rstn=1 at c4 of test 2:
//     -> On c5 all outputs are 0 and the state is IDLE.
//     -> A following start runs a full 6-cycle issue pattern.
//  6. ROW_FEEDER_STALL_CNT_EN with test 3:
//     -> stall_cycles=2 after done.
//     -> stall_cycles=0 on c1 of the next tile.

Source files
------------

// File: rtl/row_skew_feeder_pkg.sv
// Shared types and default sizing for the row skew feeder.
package row_skew_feeder_pkg;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_FEED,
        FS_DRAIN,
        FS_DONE
    } feeder_state_t;

    // Default array geometry used when instantiating the feeder.
    localparam int SA_ROWS   = 4;
    localparam int SA_DWIDTH = 16;

    // Issue-counter value of the last pop of a tile (last row, last operand).
    function automatic int last_issue(input int rows, input int k_len);
        return rows + k_len - 2;
    endfunction

endpackage

// File: rtl/row_skew_feeder_lane.sv
// One row of the skewed feeder: decides whether this row pops in the current
// cycle, registers the pop as the lane valid, and masks the buffer's stale dout.
module row_feeder_lane
    import row_skew_feeder_pkg::*;
#(
    parameter int LANE   = 0,
    parameter int DWIDTH = 16,
    parameter int K_LEN  = 3,
    parameter int TW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TW-1:0]     t,
    input  feeder_state_t     state,
    input  logic              stall,
    input  logic [DWIDTH-1:0] dout,
    output logic              active,
    output logic              rd_en,
    output logic              valid,
    output logic [DWIDTH-1:0] data
);

    // Offset of the issue counter from this row's start; wraps when t < LANE.
    logic [31:0] offset;

    // Row window: this row pops while LANE <= t < LANE+K_LEN, gated by FEED and stall.
    always_comb begin
        offset = 32'(t) - 32'(LANE);
        active = (offset < 32'(K_LEN));
        rd_en  = (state == FS_FEED) && active && !stall;
        data   = valid ? dout : '0;
    end

    // Valid follows the pop by one cycle, lining up with the buffer's registered dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else begin
            valid <= rd_en;
        end
    end

endmodule

// File: rtl/row_skew_feeder.sv
// Row skew feeder: pops ROWS row buffers in a diagonal wavefront, stalls all
// rows together on any underrun, and signals tile completion.
// Optional build macro ROW_FEEDER_STALL_CNT_EN adds the stall_cycles counter port.
// Handshake: a row pops (buf_rd_en) only when its buffer is not empty; the
// array edge takes sa_data whenever sa_valid is high and never back-pressures.
module row_skew_feeder
    import row_skew_feeder_pkg::*;
#(
    parameter int ROWS   = SA_ROWS,
    parameter int DWIDTH = SA_DWIDTH,
    parameter int K_LEN  = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [ROWS-1:0]          buf_empty,
    input  logic [ROWS*DWIDTH-1:0]   buf_dout,
    output logic [ROWS-1:0]          buf_rd_en,
    output logic [ROWS*DWIDTH-1:0]   sa_data,
    output logic [ROWS-1:0]          sa_valid,
    output logic                     busy,
    output logic                     done
`ifdef ROW_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int            TW     = $clog2(ROWS + K_LEN);
    localparam logic [TW-1:0] T_LAST = TW'(last_issue(ROWS, K_LEN));

    feeder_state_t   state;
    feeder_state_t   state_next;
    logic [TW-1:0]   t;
    logic [ROWS-1:0] active;
    logic            stall;

    // Any active row with an empty buffer freezes the whole wavefront.
    always_comb begin
        stall = |(active & buf_empty);
    end

    // State register; rstn is an active-high synchronous reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= FS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            FS_IDLE: begin
                if (start) state_next = FS_FEED;
            end
            FS_FEED: begin
                busy = 1'b1;
                if (!stall && (t == T_LAST)) state_next = FS_DRAIN;
            end
            FS_DRAIN: begin
                busy       = 1'b1;
                state_next = FS_DONE;
            end
            FS_DONE: begin
                done       = 1'b1;
                state_next = FS_IDLE;
            end
            default: state_next = FS_IDLE;
        endcase
    end

    // Issue counter: cleared on tile start, advanced on each non-stalled FEED cycle.
    always_ff @(posedge clk) begin
        if (rstn) begin
            t <= '0;
        end else if ((state == FS_IDLE) && start) begin
            t <= '0;
        end else if ((state == FS_FEED) && !stall) begin
            t <= t + TW'(1);
        end
    end

    // One lane per row buffer.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        row_feeder_lane #(
            .LANE   (r),
            .DWIDTH (DWIDTH),
            .K_LEN  (K_LEN),
            .TW     (TW)
        ) u_lane (
            .clk    (clk),
            .rst    (rstn),
            .t      (t),
            .state  (state),
            .stall  (stall),
            .dout   (buf_dout[r*DWIDTH +: DWIDTH]),
            .active (active[r]),
            .rd_en  (buf_rd_en[r]),
            .valid  (sa_valid[r]),
            .data   (sa_data[r*DWIDTH +: DWIDTH])
        );
    end

`ifdef ROW_FEEDER_STALL_CNT_EN
    // Saturating count of stalled FEED cycles; kept after DONE until the next start.
    always_ff @(posedge clk) begin
        if (rstn) begin
            stall_cycles <= '0;
        end else if ((state == FS_IDLE) && start) begin
            stall_cycles <= '0;
        end else if ((state == FS_FEED) && stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_row_skew_feeder.sv
// Bench for row_skew_feeder (ROWS=4, DWIDTH=16, K_LEN=3): directed vector
// tables, hand-written corner sequences and random tiles against a model.
module tb_row_skew_feeder;

  localparam int ROWS = 4;
  localparam int DW   = 16;
  localparam int K    = 3;
  localparam int P_IDLE = 0, P_FEED = 1, P_DRAIN = 2, P_DONE = 3;

  logic                 clk;
  logic                 rstn;
  logic                 start;
  logic [ROWS-1:0]      buf_empty;
  logic [ROWS*DW-1:0]   buf_dout;
  logic [ROWS-1:0]      buf_rd_en;
  logic [ROWS*DW-1:0]   sa_data;
  logic [ROWS-1:0]      sa_valid;
  logic                 busy;
  logic                 done;
`ifdef ROW_FEEDER_STALL_CNT_EN
  logic [31:0]          stall_cycles;
`endif

  row_skew_feeder #(.ROWS(ROWS), .DWIDTH(DW), .K_LEN(K)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .buf_empty (buf_empty),
    .buf_dout  (buf_dout),
    .buf_rd_en (buf_rd_en),
    .sa_data   (sa_data),
    .sa_valid  (sa_valid),
    .busy      (busy),
    .done      (done)
`ifdef ROW_FEEDER_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- row buffer environment ----------------
  logic [DW-1:0] tile_data [ROWS][K];
  int env_ptr [ROWS];
  int mdl_ptr [ROWS];

  function automatic logic [DW-1:0] tile_word(input int r, input int p);
    if (p < K) return tile_data[r][p];
    return 16'hDEAD;
  endfunction

  task automatic load_tile(input bit rand_data);
    for (int r = 0; r < ROWS; r++) begin
      for (int j = 0; j < K; j++)
        tile_data[r][j] = rand_data ? DW'($urandom_range(0, 65535)) : DW'(r*16 + j + 1);
      env_ptr[r] = 0;
      mdl_ptr[r] = 0;
    end
  endtask

  // ---------------- reference model ----------------
  // Wavefront step k: row r may pop once k >= r until it has popped K operands.
  // The tile ends when the last row has popped its K-th operand.
  int              m_phase;
  int              m_step;
  int              m_pops [ROWS];
  logic [ROWS-1:0] m_valid;
  logic [DW-1:0]   m_data [ROWS];
  longint          m_stall_cnt;
  logic [ROWS-1:0] e_rd;
  logic            e_stalled;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_step = 0;
    m_valid = '0;
    m_stall_cnt = 0;
    for (int r = 0; r < ROWS; r++) begin
      m_pops[r] = 0;
      m_data[r] = '0;
    end
  endtask

  task automatic model_comb();
    logic [ROWS-1:0] want;
    want = '0;
    e_stalled = 1'b0;
    if (m_phase == P_FEED)
      for (int r = 0; r < ROWS; r++) begin
        want[r] = (m_step >= r) && (m_pops[r] < K);
        if (want[r] && buf_empty[r]) e_stalled = 1'b1;
      end
    e_rd = e_stalled ? '0 : want;
  endtask

  task automatic model_seq(input logic s, input logic rst);
    // Buffers pop on rd_en regardless of this block's reset.
    for (int r = 0; r < ROWS; r++)
      if (e_rd[r]) begin
        m_data[r] = tile_word(r, mdl_ptr[r]);
        mdl_ptr[r]++;
        m_pops[r]++;
      end
    if (rst) begin
      model_reset();
    end else begin
      m_valid = e_rd;
      case (m_phase)
        P_IDLE: if (s) begin
          m_phase = P_FEED;
          m_step = 0;
          m_stall_cnt = 0;
          for (int r = 0; r < ROWS; r++) m_pops[r] = 0;
        end
        P_FEED: begin
          if (e_stalled) begin
            if (m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
          end else begin
            m_step++;
          end
          if (m_pops[ROWS-1] == K) m_phase = P_DRAIN;
        end
        P_DRAIN: m_phase = P_DONE;
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  logic [ROWS-1:0]    s_rd, s_valid;
  logic [ROWS*DW-1:0] s_data;
  logic               s_busy, s_done;
  logic [31:0]        s_stall;

  task automatic cycle(input logic s, input logic rst, input logic [ROWS-1:0] e);
    logic [ROWS*DW-1:0] exp_data;
    start = s;
    rstn = rst;
    buf_empty = e;
    model_comb();
    exp_data = '0;
    for (int r = 0; r < ROWS; r++)
      if (m_valid[r]) exp_data[r*DW +: DW] = m_data[r];
    @(negedge clk);
    s_rd = buf_rd_en;
    s_valid = sa_valid;
    s_data = sa_data;
    s_busy = busy;
    s_done = done;
    check("rd_en", 64'(s_rd), 64'(e_rd));
    check("sa_valid", 64'(s_valid), 64'(m_valid));
    check("sa_data", 64'(s_data), 64'(exp_data));
    check("busy", 64'(s_busy), 64'(m_phase == P_FEED || m_phase == P_DRAIN));
    check("done", 64'(s_done), 64'(m_phase == P_DONE));
`ifdef ROW_FEEDER_STALL_CNT_EN
    s_stall = stall_cycles;
    check("stall_cycles", 64'(s_stall), 64'(m_stall_cnt));
`else
    s_stall = '0;
`endif
    @(posedge clk);
    #1;
    for (int r = 0; r < ROWS; r++)
      if (s_rd[r]) begin
        buf_dout[r*DW +: DW] = tile_word(r, env_ptr[r]);
        env_ptr[r]++;
      end
    model_seq(s, rst);
  endtask

  task automatic run_to_idle(input string name);
    int n;
    n = 0;
    while (m_phase != P_IDLE && n < 200) begin
      cycle(1'b0, 1'b0, '0);
      n++;
    end
    check({name, "_idle_bound"}, 64'(m_phase), 64'(P_IDLE));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            start;
    logic [ROWS-1:0] empty;
    logic [ROWS-1:0] rd;
    logic [ROWS-1:0] valid;
    logic            busy;
    logic            done;
    logic [DW-1:0]   d2;
  } vec_t;

  vec_t tbl [22];

  initial begin
    logic [ROWS-1:0] pat [6];
    int dones;

    // Basic tile: c0..c9
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0011, 4'b0001, 1'b1, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0111, 4'b0011, 1'b1, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 4'b0000, 4'b1110, 4'b0111, 1'b1, 1'b0, 16'h0021};
    tbl[5]  = '{1'b0, 4'b0000, 4'b1100, 4'b1110, 1'b1, 1'b0, 16'h0022};
    tbl[6]  = '{1'b0, 4'b0000, 4'b1000, 4'b1100, 1'b1, 1'b0, 16'h0023};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b1, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'h0000};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000};
    // Row 1 empty on c2..c3: c0..c11
    tbl[10] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000};
    tbl[11] = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 16'h0000};
    tbl[12] = '{1'b0, 4'b0010, 4'b0000, 4'b0001, 1'b1, 1'b0, 16'h0000};
    tbl[13] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000};
    tbl[14] = '{1'b0, 4'b0000, 4'b0011, 4'b0000, 1'b1, 1'b0, 16'h0000};
    tbl[15] = '{1'b0, 4'b0000, 4'b0111, 4'b0011, 1'b1, 1'b0, 16'h0000};
    tbl[16] = '{1'b0, 4'b0000, 4'b1110, 4'b0111, 1'b1, 1'b0, 16'h0021};
    tbl[17] = '{1'b0, 4'b0000, 4'b1100, 4'b1110, 1'b1, 1'b0, 16'h0022};
    tbl[18] = '{1'b0, 4'b0000, 4'b1000, 4'b1100, 1'b1, 1'b0, 16'h0023};
    tbl[19] = '{1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b1, 1'b0, 16'h0000};
    tbl[20] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'h0000};
    tbl[21] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000};

    pat[0] = 4'b0001; pat[1] = 4'b0011; pat[2] = 4'b0111;
    pat[3] = 4'b1110; pat[4] = 4'b1100; pat[5] = 4'b1000;

    start = 1'b0;
    rstn = 1'b1;
    buf_empty = '0;
    buf_dout = '0;
    load_tile(1'b0);
    model_reset();
    @(posedge clk);
    #1;

    // Reset held for two cycles: everything quiet.
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);
    check("reset_rd_en", 64'(s_rd), 64'd0);
    check("reset_busy", 64'(s_busy), 64'd0);

    // Basic tile and stalled tile from the table.
    for (int i = 0; i < 22; i++) begin
      if (i == 10) load_tile(1'b0);
      cycle(tbl[i].start, 1'b0, tbl[i].empty);
      check($sformatf("tbl%0d_rd", i), 64'(s_rd), 64'(tbl[i].rd));
      check($sformatf("tbl%0d_valid", i), 64'(s_valid), 64'(tbl[i].valid));
      check($sformatf("tbl%0d_busy", i), 64'(s_busy), 64'(tbl[i].busy));
      check($sformatf("tbl%0d_done", i), 64'(s_done), 64'(tbl[i].done));
      check($sformatf("tbl%0d_d2", i), 64'(s_data[2*DW +: DW]), 64'(tbl[i].d2));
    end
`ifdef ROW_FEEDER_STALL_CNT_EN
    check("stall_cnt_after_done", 64'(s_stall), 64'd2);
`endif

    // start held high through a tile: one tile, then a new one right after IDLE.
    load_tile(1'b0);
    dones = 0;
    for (int i = 0; i <= 10; i++) begin
      cycle(1'b1, 1'b0, '0);
      if (s_done) dones++;
`ifdef ROW_FEEDER_STALL_CNT_EN
      if (i == 1) check("stall_cnt_new_tile", 64'(s_stall), 64'd0);
`endif
      if (i == 8) check("held_start_done_c8", 64'(s_done), 64'd1);
      if (i == 9) check("held_start_idle_c9", 64'({s_busy, s_rd}), 64'd0);
      if (i == 10) check("held_start_restart_c10", 64'(s_rd), 64'b0001);
    end
    check("held_start_one_done", 64'(dones), 64'd1);
    run_to_idle("held_start");

    // Reset during c4 of a tile aborts it; a new tile then runs in full.
    load_tile(1'b0);
    cycle(1'b1, 1'b0, '0);
    for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);
    check("abort_outputs", 64'({s_rd, s_valid, s_busy, s_done}), 64'd0);
    check("abort_data", 64'(s_data), 64'd0);
    load_tile(1'b0);
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, '0);
      check($sformatf("restart_rd_c%0d", i + 1), 64'(s_rd), 64'(pat[i]));
    end
    run_to_idle("restart");

    // Random tiles: random data, underruns, stray starts and occasional resets.
    for (int tile = 0; tile < 40; tile++) begin
      int n;
      load_tile(1'b1);
      repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, '0);
      n = 0;
      while (m_phase != P_IDLE && n < 200) begin
        logic [ROWS-1:0] e;
        for (int r = 0; r < ROWS; r++) e[r] = ($urandom_range(0, 9) == 0);
        cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0), e);
        n++;
      end
      check("rand_idle_bound", 64'(m_phase), 64'(P_IDLE));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
